mole_round_sequencer: RTL and testbench
=======================================

Name: mole_round_sequencer

Overview:
Round controller that sequences the unique-number selector for one whack-a-mole round. It requests a fresh mole index, lights that mole for a timed window, and scores the player's hit or miss. It then waits an inter-mole gap and repeats until the selector reports all indices used. It replaces the free-running one-second request loop in the top level and sits between the selector, the player button decoder and the display/LED drivers.

Parameters:
WINDOW_CYCLES, 50_000_000, clock cycles a mole stays lit (>=1)
GAP_CYCLES, 12_500_000, clock cycles all moles dark between moles (>=1)
DONE_TIMEOUT, 16, max cycles waiting for selector done before fault (>=1)
CNT_W, 32, width of the shared window/gap/timeout counter (must hold max of the above)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  begin round; sampled only in IDLE
sel_req  output  1  one-cycle request pulse to the unique selector
sel_done  input  1  selector result valid this cycle
sel_number  input  3  selector result index 0..7
sel_all  input  1  selector has issued all 8 indices
hit_valid  input  1  player press strobe, one cycle
hit_index  input  3  index of pressed button
mole_onehot  output  8  lit mole, bit i = mole i
mole_active  output  1  high while a mole is lit
cur_mole  output  3  latched index of current/last mole (for seven-seg)
hit_count  output  4  correct hits this round, saturates at 15
miss_count  output  4  expired windows this round, saturates at 15
round_done  output  1  high while in FINISH
error  output  1  high while in FAULT

Behaviour:
- All outputs registered. On rst (asynchronous): state=IDLE, counter=0, every output 0.
- States: IDLE, REQ, WAIT_DONE, SHOW, GAP, FINISH, FAULT.
- IDLE: start=1 and sel_all=0 -> REQ. start=1 and sel_all=1 -> FINISH. Otherwise hold.
- REQ: sel_req=1 for exactly this one cycle; counter cleared; next state WAIT_DONE. start high at edge N gives sel_req high during cycle N+1 only.
- WAIT_DONE: sel_req=0.
  - sel_done=1: latch cur_mole<=sel_number; counter<=0; -> SHOW. mole_onehot/mole_active take effect in the cycle after the done edge.
  - Otherwise counter increments. If counter==DONE_TIMEOUT-1 with no done -> FAULT.
- SHOW: mole_onehot=1<<cur_mole, mole_active=1. Lasts exactly WINDOW_CYCLES cycles unless a hit occurs.
  - hit_valid=1 and hit_index==cur_mole: hit_count+1 (saturating); -> GAP.
  - hit_valid with wrong index: ignored, no score change.
  - Window expiry: counter==WINDOW_CYCLES-1 without a correct hit -> miss_count+1 (saturating); -> GAP.
  - Correct hit on the expiry cycle: counts as hit only; miss unchanged.
  - Entering GAP clears mole_onehot/mole_active and the counter.
- GAP: all moles dark for exactly GAP_CYCLES cycles. On the last cycle, sample sel_all: 1 -> FINISH, 0 -> REQ.
- FINISH: round_done=1; cur_mole and counts held; terminal until rst. start is ignored.
- FAULT: error=1; sel_req never reasserted; terminal until rst.
- start is ignored outside IDLE. hit_valid is ignored outside SHOW. sel_done outside WAIT_DONE is ignored.
- Counter width CNT_W. Compares are equality against parameter-1, so the counter never wraps.
- rst asserted mid-round (any state) aborts immediately: outputs 0, no pending sel_req.

Test Plan:
(Bench parameters for all scenarios: WINDOW_CYCLES=10, GAP_CYCLES=4, DONE_TIMEOUT=5.)
1. Reset, start pulse, selector model returns done 2 cycles after req with sel_number=3 -> sel_req high exactly 1 cycle; mole_onehot=8'h08, cur_mole=3 the cycle after done.
2. In SHOW press hit_index=3 on the 3rd window cycle -> hit_count=1, miss_count=0, mole_onehot=0 next cycle; next sel_req exactly 4 cycles after GAP entry.
3. In SHOW press hit_index=5 only -> no score change; mole lit exactly 10 cycles, then miss_count=1.
4. Correct hit on the 10th (expiry) window cycle -> hit_count=1, miss_count=0.
5. Selector model never asserts done -> error=1 after 5 WAIT_DONE cycles; no further sel_req; start ignored until rst.
6. Full round, selector model yields 8 distinct indices and raises sel_all after the 8th:
   - alternate hits and misses -> exactly 8 sel_req pulses, hit_count=4, miss_count=4, round_done=1 held.
   - rst asserted mid-SHOW on a repeat run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round controller: requests unique mole indices, lights each one for a timed
// window, scores hits and misses, and spaces moles with a dark gap until the selector is exhausted.
module mole_round_sequencer #(
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES    = 12_500_000,
    parameter int unsigned DONE_TIMEOUT  = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sel_req,
    input  logic       sel_done,
    input  logic [2:0] sel_number,
    input  logic       sel_all,
    input  logic       hit_valid,
    input  logic [2:0] hit_index,
    output logic [7:0] mole_onehot,
    output logic       mole_active,
    output logic [2:0] cur_mole,
    output logic [3:0] hit_count,
    output logic [3:0] miss_count,
    output logic       round_done,
    output logic       error
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SHOW      = 3'd3,
        ST_GAP       = 3'd4,
        ST_FINISH    = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(DONE_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_cur, w_cur_next;
    logic [3:0]       r_hit, r_miss, w_hit_next, w_miss_next;
    logic             r_sel_req, r_active, r_round_done, r_error;
    logic [7:0]       r_onehot;
    logic             w_good_hit;

    // Next-state, score and latched-mole decisions.
    always_comb begin
        w_next      = r_state;
        w_cur_next  = r_cur;
        w_hit_next  = r_hit;
        w_miss_next = r_miss;
        w_good_hit  = hit_valid && (hit_index == r_cur);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = sel_all ? ST_FINISH : ST_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (sel_done) begin
                    w_cur_next = sel_number;
                    w_next     = ST_SHOW;
                end else if (r_cnt == TO_LAST) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_SHOW: begin
                // A correct press on the expiry cycle is scored as a hit only.
                if (w_good_hit) begin
                    w_hit_next = sat_inc(r_hit);
                    w_next     = ST_GAP;
                end else if (r_cnt == WIN_LAST) begin
                    w_miss_next = sat_inc(r_miss);
                    w_next      = ST_GAP;
                end else begin
                    w_next = ST_SHOW;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_next = sel_all ? ST_FINISH : ST_REQ;
                end else begin
                    w_next = ST_GAP;
                end
            end
            ST_FINISH: w_next = ST_FINISH;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_FAULT;
        endcase
    end

    // Shared timer restarts on every state change and only runs in timed states.
    always_comb begin
        if (w_next != r_state) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if ((r_state == ST_WAIT_DONE) || (r_state == ST_SHOW) || (r_state == ST_GAP)) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // State, counter, scores and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_cur        <= 3'd0;
            r_hit        <= 4'd0;
            r_miss       <= 4'd0;
            r_sel_req    <= 1'b0;
            r_onehot     <= 8'd0;
            r_active     <= 1'b0;
            r_round_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_cur        <= w_cur_next;
            r_hit        <= w_hit_next;
            r_miss       <= w_miss_next;
            r_sel_req    <= (w_next == ST_REQ);
            r_onehot     <= (w_next == ST_SHOW) ? (8'd1 << w_cur_next) : 8'd0;
            r_active     <= (w_next == ST_SHOW);
            r_round_done <= (w_next == ST_FINISH);
            r_error      <= (w_next == ST_FAULT);
        end
    end

    assign sel_req     = r_sel_req;
    assign mole_onehot = r_onehot;
    assign mole_active = r_active;
    assign cur_mole    = r_cur;
    assign hit_count   = r_hit;
    assign miss_count  = r_miss;
    assign round_done  = r_round_done;
    assign error       = r_error;
endmodule

// File: tb/tb_mole_round_sequencer.sv
// Self-checking bench for mole_round_sequencer: randomized selector latency, mole indices and
// press timing, scored against a per-mole outcome model (hit if a correct press lands in the window).
module tb_mole_round_sequencer;
    localparam int WIN = 10;
    localparam int GAP = 4;
    localparam int TO  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sel_done = 1'b0;
    logic [2:0] sel_number = 3'd0;
    logic       sel_all = 1'b0;
    logic       hit_valid = 1'b0;
    logic [2:0] hit_index = 3'd0;
    logic       sel_req, mole_active, round_done, error;
    logic [7:0] mole_onehot;
    logic [2:0] cur_mole;
    logic [3:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mole_round_sequencer #(
        .WINDOW_CYCLES(WIN), .GAP_CYCLES(GAP), .DONE_TIMEOUT(TO), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sel_req(sel_req), .sel_done(sel_done),
        .sel_number(sel_number), .sel_all(sel_all), .hit_valid(hit_valid), .hit_index(hit_index),
        .mole_onehot(mole_onehot), .mole_active(mole_active), .cur_mole(cur_mole),
        .hit_count(hit_count), .miss_count(miss_count), .round_done(round_done), .error(error)
    );

    function automatic logic [22:0] all_outs();
        return {sel_req, mole_onehot, mole_active, cur_mole, hit_count, miss_count, round_done, error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, then pulse start; returns at #1 in the cycle after the start edge.
    task automatic begin_round();
        rst = 1'b1; start = 1'b0; sel_done = 1'b0; sel_all = 1'b0; hit_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (sel_req !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
    endtask

    // Selector model: measures the request pulse, waits lat WAIT_DONE cycles, returns num.
    task automatic serve(input logic [2:0] num, input int lat, input logic all_after, output int req_len);
        req_len = 0;
        while (sel_req === 1'b1 && req_len < 5) begin
            req_len++;
            tick();
        end
        repeat (lat) tick();
        sel_done = 1'b1; sel_number = num; sel_all = all_after;
        tick();
        sel_done = 1'b0; sel_number = 3'($urandom_range(0, 7));
    endtask

    // Player model: presses at window cycle hit_at (correct) and/or wrong_at (wrong index).
    task automatic run_window(input logic [2:0] idx, input int hit_at, input int wrong_at,
                              input logic [2:0] wrong_idx, output int lit, output int bad);
        logic [7:0] exp_oh;
        exp_oh = 8'd0;
        exp_oh[idx] = 1'b1;
        lit = 0; bad = 0;
        for (int c = 1; c <= WIN + 3; c++) begin
            if (mole_active !== 1'b1) break;
            lit++;
            if (mole_onehot !== exp_oh) bad++;
            hit_valid = (c == hit_at) || (c == wrong_at);
            hit_index = (c == hit_at) ? idx : wrong_idx;
            tick();
            hit_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (all_outs() !== 23'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
        rst = 1'b0; sel_all = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (round_done !== 1'b1 || sel_req !== 1'b0) begin n_bad++; $display("FAIL start_all_used: round_done=%b sel_req=%b expected 1/0", round_done, sel_req); end
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        n_cmp++; if (round_done !== 1'b1 || sel_req !== 1'b0) begin n_bad++; $display("FAIL finish_ignores_start: round_done=%b sel_req=%b expected 1/0", round_done, sel_req); end
        sel_all = 1'b0;
    endtask

    task automatic test_first_mole();
        int w, len;
        begin_round();
        wait_req(w);
        n_cmp++; if (w !== 0 || sel_req !== 1'b1) begin n_bad++; $display("FAIL req_after_start: delay=%0d sel_req=%b expected 0/1", w, sel_req); end
        serve(3'd3, 1, 1'b0, len);
        n_cmp++; if (len !== 1) begin n_bad++; $display("FAIL req_pulse_len: got %0d expected 1", len); end
        n_cmp++; if (mole_onehot !== 8'h08 || cur_mole !== 3'd3 || mole_active !== 1'b1) begin
            n_bad++; $display("FAIL first_mole_lit: onehot=%h cur=%0d active=%b expected 08/3/1", mole_onehot, cur_mole, mole_active); end
    endtask

    task automatic test_correct_hit();
        int lit, bad, w;
        run_window(3'd3, 3, 0, 3'd0, lit, bad);
        n_cmp++; if (lit !== 3 || bad !== 0) begin n_bad++; $display("FAIL hit_lit_cycles: lit=%0d bad=%0d expected 3/0", lit, bad); end
        n_cmp++; if (hit_count !== 4'd1 || miss_count !== 4'd0 || mole_onehot !== 8'd0) begin
            n_bad++; $display("FAIL hit_score: hit=%0d miss=%0d onehot=%h expected 1/0/00", hit_count, miss_count, mole_onehot); end
        wait_req(w);
        n_cmp++; if (w !== GAP || sel_req !== 1'b1) begin n_bad++; $display("FAIL gap_length: got %0d expected %0d", w, GAP); end
    endtask

    task automatic test_wrong_press();
        int w, len, lit, bad;
        logic [2:0] idx, wrong;
        begin_round();
        wait_req(w);
        idx = 3'($urandom_range(0, 7));
        wrong = 3'((int'(idx) + 1 + int'($urandom_range(0, 6))) % 8);
        serve(idx, int'($urandom_range(0, 3)), 1'b0, len);
        run_window(idx, 0, int'($urandom_range(1, WIN)), wrong, lit, bad);
        n_cmp++; if (lit !== WIN || bad !== 0) begin n_bad++; $display("FAIL wrong_press_lit: lit=%0d bad=%0d expected %0d/0", lit, bad, WIN); end
        n_cmp++; if (hit_count !== 4'd0 || miss_count !== 4'd1) begin n_bad++; $display("FAIL wrong_press_score: hit=%0d miss=%0d expected 0/1", hit_count, miss_count); end
    endtask

    task automatic test_expiry_hit();
        int w, len, lit, bad;
        logic [2:0] idx;
        begin_round();
        wait_req(w);
        idx = 3'($urandom_range(0, 7));
        serve(idx, int'($urandom_range(0, 3)), 1'b0, len);
        run_window(idx, WIN, 0, 3'd0, lit, bad);
        n_cmp++; if (lit !== WIN) begin n_bad++; $display("FAIL expiry_hit_lit: got %0d expected %0d", lit, WIN); end
        n_cmp++; if (hit_count !== 4'd1 || miss_count !== 4'd0) begin n_bad++; $display("FAIL expiry_hit_score: hit=%0d miss=%0d expected 1/0", hit_count, miss_count); end
    endtask

    task automatic test_timeout();
        int w, k, reqs;
        begin_round();
        wait_req(w);
        tick();
        k = 0; reqs = 0;
        while (error !== 1'b1 && k < 20) begin
            if (sel_req === 1'b1) reqs++;
            tick();
            k++;
        end
        n_cmp++; if (k !== TO || error !== 1'b1) begin n_bad++; $display("FAIL timeout_cycles: got %0d expected %0d", k, TO); end
        for (int i = 0; i < 15; i++) begin
            start = (i % 3 == 0);
            sel_done = (i == 4);
            tick();
            if (sel_req === 1'b1 || mole_active === 1'b1) reqs++;
        end
        start = 1'b0; sel_done = 1'b0;
        n_cmp++; if (reqs !== 0 || error !== 1'b1) begin n_bad++; $display("FAIL fault_terminal: stray=%0d error=%b expected 0/1", reqs, error); end
    endtask

    task automatic test_full_round();
        int perm[8];
        int w, len, lit, bad, hit_at, pulses, exp_hit, exp_miss, exp_lit, tmp, j;
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        begin_round();
        pulses = 0; exp_hit = 0; exp_miss = 0;
        for (int i = 0; i < 8; i++) begin
            wait_req(w);
            n_cmp++; if (sel_req !== 1'b1) begin n_bad++; $display("FAIL round_req_%0d: sel_req=%b expected 1", i, sel_req); break; end
            pulses++;
            serve(3'(perm[i]), int'($urandom_range(0, 3)), (i == 7), len);
            hit_at = (i % 2 == 0) ? int'($urandom_range(1, WIN)) : 0;
            run_window(3'(perm[i]), hit_at, (hit_at == 0) ? int'($urandom_range(1, WIN)) : 0,
                       3'(perm[i] + 4), lit, bad);
            exp_lit = (hit_at >= 1 && hit_at <= WIN) ? hit_at : WIN;
            if (hit_at >= 1 && hit_at <= WIN) exp_hit++; else exp_miss++;
            n_cmp++; if (lit !== exp_lit || bad !== 0 || cur_mole !== 3'(perm[i])) begin
                n_bad++; $display("FAIL round_mole_%0d: lit=%0d bad=%0d cur=%0d expected %0d/0/%0d", i, lit, bad, cur_mole, exp_lit, perm[i]); end
        end
        for (int k = 0; k < 12; k++) begin
            start = (k == 8);
            if (sel_req === 1'b1) pulses++;
            tick();
        end
        start = 1'b0;
        n_cmp++; if (pulses !== 8) begin n_bad++; $display("FAIL round_req_count: got %0d expected 8", pulses); end
        n_cmp++; if (hit_count !== 4'(exp_hit) || miss_count !== 4'(exp_miss)) begin
            n_bad++; $display("FAIL round_score: hit=%0d miss=%0d expected %0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
        n_cmp++; if (round_done !== 1'b1 || cur_mole !== 3'(perm[7]) || mole_active !== 1'b0) begin
            n_bad++; $display("FAIL round_finish: done=%b cur=%0d active=%b expected 1/%0d/0", round_done, cur_mole, mole_active, perm[7]); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (all_outs() !== 23'd0) begin n_bad++; $display("FAIL finish_async_reset: got %h expected 0", all_outs()); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_show();
        int w, len;
        begin_round();
        wait_req(w);
        serve(3'($urandom_range(0, 7)), 1, 1'b0, len);
        tick(); tick();
        n_cmp++; if (mole_active !== 1'b1) begin n_bad++; $display("FAIL mid_show_lit: active=%b expected 1", mole_active); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (all_outs() !== 23'd0) begin n_bad++; $display("FAIL mid_show_async_reset: got %h expected 0", all_outs()); end
        tick();
        rst = 1'b0;
        tick(); tick();
        n_cmp++; if (all_outs() !== 23'd0) begin n_bad++; $display("FAIL after_reset_idle: got %h expected 0", all_outs()); end
    endtask

    initial begin
        test_reset();
        test_first_mole();
        test_correct_hit();
        test_wrong_press();
        test_expiry_hit();
        test_timeout();
        test_full_round();
        test_full_round();
        test_reset_mid_show();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
